register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised successor of the single-write, two-read 32x32 register file.
- Configurable data width, depth, read-port count and write-port count.
- Reads are registered with one-cycle latency.
- A per-register busy scoreboard supports the multi-issue datapath; register 0 reads as zero.
- Sits between decode (read ports, reservations) and writeback (write ports) of the pipelined core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, implemented registers (must be <= 2**ADDR_W, >= 2)
NUM_RD, 2, read ports (1..8)
NUM_WR, 2, write ports (1..4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
raddr  input  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
rbusy  output  NUM_RD  registered busy flag of each read address
we  input  NUM_WR  write enable per write port
waddr  input  NUM_WR*ADDR_W  write addresses
wdata  input  NUM_WR*DATA_W  write data
rsv_en  input  1  reserve (mark busy) request
rsv_addr  input  ADDR_W  register to reserve

Behaviour:
- Reset (rst=0, asynchronous assert):
  - All registers are 0.
  - rdata is 0 and rbusy is 0 immediately, independent of clk.
  - Deassertion is sampled synchronously; the first update happens on the first rising edge with rst=1.
- Write:
  - On a rising edge, each port w with we[w]=1 and waddr_w != 0 and waddr_w < NUM_REGS writes wdata_w.
  - Writes to address 0 or out-of-range addresses are dropped silently.
  - Two ports writing the same address in one cycle: the highest port index wins.
- Read:
  - On each rising edge, rdata[p] is loaded from raddr[p] sampled at that edge; latency 1 cycle.
  - Address 0 or an out-of-range address returns 0 and rbusy=0.
  - Same-edge write to the read address: behaviour depends on BYPASS_EN (see below).
- Scoreboard (one busy bit per register):
  - rsv_en=1 sets busy[rsv_addr] at the edge; ignored for address 0 or out-of-range.
  - A dropped write never clears a busy bit.
  - Any accepted write clears busy[waddr].
  - Reserve and write to the same address in one cycle: the reserve wins (busy stays 1) and the data is still written.
- rbusy[p]: loaded each edge with the busy state of raddr[p], under the same bypass rule as rdata.
- Reset mid-operation: in-flight writes and reservations in that cycle are discarded.
- No X propagation: rdata never shows an uninitialised value.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-first. A read whose address matches an accepted same-edge write returns the new wdata, using the highest-index matching port. rbusy reflects the post-update scoreboard.
- Undefined: read-first. A read returns the register and busy values from before the edge. Saves the bypass comparators.

Decomposition:
- Package rf_pkg holds:
  - Default constants RF_DATA_W=32, RF_ADDR_W=5, RF_NUM_REGS=32.
  - Typedefs rf_data_t and rf_addr_t.
  - Function rf_addr_valid(addr), true for nonzero, in-range addresses.
- Sub-module rf_read_port, instantiated NUM_RD times via generate. Each instance contains:
  - The address mux.
  - The zero/range check.
  - The optional bypass compare across write ports.
  - The rdata/rbusy output registers.
- Write decode and the scoreboard stay in the top module.

Test Plan:
- Reset: write r5=0x0000_00FF, reserve r6, then pulse rst=0 between edges -> rdata and rbusy become 0 without a clock edge. Reading r5 afterwards returns 0.
- Basic: we[0]=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr[0]=5 -> rdata[0]=0xDEADBEEF one edge later. raddr[1]=5 gives the same value on port 1.
- Zero and range: write r0=0x1234 -> read r0 returns 0. With NUM_REGS=24, write r30=0x77 -> read r30 returns 0 and r0..r23 are unchanged.
- Port priority: we=2'b11, both waddr=7, wdata0=0xA, wdata1=0xB -> read r7 returns 0xB.
- Bypass: r3 holds 0x11; in the same cycle write r3=0x55 and raddr[0]=3 -> rdata[0]=0x55 with RF_BYPASS_EN, 0x11 without it. The following read returns 0x55 in both builds.
- Scoreboard:
  - Reserve r9 -> a read of r9 gives rbusy=1.
  - Write r9=0x9 -> rbusy=0 and rdata=0x9.
  - Simultaneous reserve and write of r9=0x10 -> rbusy=1 and rdata=0x10.
  - Reserve r0 -> rbusy stays 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants, types and address helper for the multi-port register file.
// Optional write-first read bypass is enabled by defining RF_BYPASS_EN.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  function automatic logic rf_addr_valid(
    input int unsigned addr,
    input int unsigned num_regs = RF_NUM_REGS
  );
    return (addr != 0) && (addr < num_regs);
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address mux, zero/range check, optional bypass.
// Write-first forwarding is compiled in when RF_BYPASS_EN is defined.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_WR   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]        busy,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rbusy
);
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rbusy_d, rbusy_q;
  logic              unused_in;

  always_comb begin
    rdata_d = '0;
    rbusy_d = 1'b0;
    if (rf_addr_valid(32'(raddr), NUM_REGS)) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (raddr == ADDR_W'(r)) begin
          rdata_d = regs[r*DATA_W +: DATA_W];
          rbusy_d = busy[r];
        end
      end
`ifdef RF_BYPASS_EN
      // later ports override earlier ones, matching write priority
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && (waddr[w*ADDR_W +: ADDR_W] == raddr)) begin
          rdata_d = wdata[w*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

`ifdef RF_BYPASS_EN
  assign unused_in = ^{busy[0], regs[DATA_W-1:0]};
`else
  assign unused_in = ^{busy[0], regs[DATA_W-1:0], we, waddr, wdata};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      rbusy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard and registered reads.
// Define RF_BYPASS_EN for write-first reads; default build is read-first.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);
  logic [NUM_REGS*DATA_W-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0]        busy_d, busy_q;
  logic [NUM_REGS-1:0]        busy_rd;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && (waddr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          regs_d[r*DATA_W +: DATA_W] = wdata[w*DATA_W +: DATA_W];
          busy_d[r] = 1'b0;
        end
      end
      // reservation is applied last so it beats a same-cycle write
      if (rsv_en && (rsv_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

`ifdef RF_BYPASS_EN
  assign busy_rd = busy_d;
`else
  assign busy_rd = busy_q;
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS),
      .NUM_WR  (NUM_WR)
    ) u_rp (
      .clk  (clk),
      .rst  (rst),
      .raddr(raddr[p*ADDR_W +: ADDR_W]),
      .regs (regs_q),
      .busy (busy_rd),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .rdata(rdata[p*DATA_W +: DATA_W]),
      .rbusy(rbusy[p])
    );
  end
endmodule
